// File: rtl/button_event_pkg.sv
// Shared types and constants for the button_event block.
// Holds the gesture FSM state encoding and the counter ceiling helper.
// Imported by the top and the input synchronizer.
package button_event_pkg;

  // Gesture FSM states: idle, first press held, long press held,
  // released awaiting a second press, second press held.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_P1    = 3'd1,
    ST_LHELD = 3'd2,
    ST_W2    = 3'd3,
    ST_P2    = 3'd4
  } state_t;

  // Widest timing counter supported by cnt_max().
  localparam int unsigned CNT_W_MAX = 32;

  // All-ones value of a w-bit counter (1 <= w <= CNT_W_MAX).
  // The timing counter saturates here instead of wrapping.
  function automatic logic [CNT_W_MAX-1:0] cnt_max(input int unsigned w);
    return {CNT_W_MAX{1'b1}} >> (CNT_W_MAX - w);
  endfunction

endpackage

// File: rtl/button_event_switch_sync.sv
// Input stage: polarity normalization, multi-flop synchronizer, edge detect.
// Latency: SYNC_STAGES cycles to o_s; o_rise/o_fall are combinational from the flops.
// No backpressure: free-running every cycle.
module button_event_switch_sync
  import button_event_pkg::*;
#(
  parameter bit ACTIVE_LOW  = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic CLOCK,
  input  logic NRESET,
  input  logic i_switch,
  output logic o_s,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_p;

  // After the XOR, 1 always means "pressed", so the released level is 0
  // whatever ACTIVE_LOW is.
  assign w_p = i_switch ^ ACTIVE_LOW;

  // Shift the pressed level through the synchronizer; keep last synced value.
  always_ff @(posedge CLOCK or negedge NRESET) begin
    if (!NRESET) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_p};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_s    = r_sync[SYNC_STAGES-1];
  assign o_rise = o_s & ~r_prev;
  assign o_fall = ~o_s & r_prev;

endmodule

// File: rtl/button_event.sv
// Turns a debounced switch level into press/release/short/long/double pulses.
// Latency: PRESS/RELEASE/HOLD SYNC_STAGES+1 cycles after the switch moves.
// No backpressure: events are single-cycle pulses, consumer must sample them.
module button_event
  import button_event_pkg::*;
#(
  parameter bit ACTIVE_LOW    = 1'b0,
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_W         = 24,
  parameter int LONG_CYCLES   = 12000000,
  parameter int DOUBLE_CYCLES = 3000000
) (
  input  logic CLOCK,
  input  logic NRESET,
  input  logic SWITCHI,
  output logic PRESS,
  output logic RELEASE,
  output logic SHORT,
  output logic LONG,
  output logic DOUBLE,
  output logic HOLD
);

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DOUBLE_CYCLES - 1);

  logic             w_s;
  logic             w_rise;
  logic             w_fall;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_short;
  logic             w_long;
  logic             w_double;
  logic             r_press;
  logic             r_release;
  logic             r_short;
  logic             r_long;
  logic             r_double;
  logic             r_hold;

  button_event_switch_sync #(
    .ACTIVE_LOW  (ACTIVE_LOW),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .CLOCK    (CLOCK),
    .NRESET   (NRESET),
    .i_switch (SWITCHI),
    .o_s      (w_s),
    .o_rise   (w_rise),
    .o_fall   (w_fall)
  );

  // Gesture decode: next state, gesture event strobes and counter update.
  always_comb begin
    w_state_nxt = r_state;
    w_short     = 1'b0;
    w_long      = 1'b0;
    w_double    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) w_state_nxt = ST_P1;
      end
      ST_P1: begin
        // A release on the last counted cycle still ends as a click.
        if (w_fall) begin
          w_state_nxt = ST_W2;
        end else if (r_cnt == LONG_LAST) begin
          w_long      = 1'b1;
          w_state_nxt = ST_LHELD;
        end
      end
      ST_LHELD: begin
        if (w_fall) w_state_nxt = ST_IDLE;
      end
      ST_W2: begin
        // A second press on the timeout cycle counts as a double click.
        if (w_rise) begin
          w_double    = 1'b1;
          w_state_nxt = ST_P2;
        end else if (r_cnt == DBL_LAST) begin
          w_short     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_P2: begin
        if (w_fall) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Counter restarts on any state change and only runs while timing a window.
    w_cnt_nxt = r_cnt;
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
    end else if ((r_state == ST_P1 || r_state == ST_W2) && r_cnt != CNT_MAX) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge CLOCK or negedge NRESET) begin
    if (!NRESET) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_short   <= 1'b0;
      r_long    <= 1'b0;
      r_double  <= 1'b0;
      r_hold    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_press   <= w_rise;
      r_release <= w_fall;
      r_short   <= w_short;
      r_long    <= w_long;
      r_double  <= w_double;
      r_hold    <= w_s;
    end
  end

  assign PRESS   = r_press;
  assign RELEASE = r_release;
  assign SHORT   = r_short;
  assign LONG    = r_long;
  assign DOUBLE  = r_double;
  assign HOLD    = r_hold;

endmodule

// File: tb/tb_button_event.sv
// Self-checking bench for button_event (SYNC_STAGES=2, LONG=20, DOUBLE=10).
// Expected outputs come from a gesture model working on edge times.
// Output vectors are {HOLD,DOUBLE,LONG,SHORT,RELEASE,PRESS}.
module tb_button_event;

  localparam int SYNC  = 2;
  localparam int LAT   = SYNC + 1;
  localparam int LONGC = 20;
  localparam int DBLC  = 10;
  localparam int MAXN  = 512;
  localparam int BIG   = 1 << 20;

  logic CLOCK   = 1'b0;
  logic NRESET  = 1'b0;
  logic SWITCHI = 1'b0;
  logic PRESS, RELEASE, SHORT, LONG, DOUBLE, HOLD;

  int n_assert = 0;
  int n_fail   = 0;

  bit         lvl  [MAXN];
  logic [5:0] obs  [MAXN+1];
  logic [5:0] expv [MAXN+1];
  int         wave_len;

  button_event #(
    .ACTIVE_LOW    (1'b0),
    .SYNC_STAGES   (SYNC),
    .CNT_W         (24),
    .LONG_CYCLES   (LONGC),
    .DOUBLE_CYCLES (DBLC)
  ) dut (
    .CLOCK   (CLOCK),
    .NRESET  (NRESET),
    .SWITCHI (SWITCHI),
    .PRESS   (PRESS),
    .RELEASE (RELEASE),
    .SHORT   (SHORT),
    .LONG    (LONG),
    .DOUBLE  (DOUBLE),
    .HOLD    (HOLD)
  );

  always #5 CLOCK = ~CLOCK;

  function automatic logic [5:0] pack_out();
    return {HOLD, DOUBLE, LONG, SHORT, RELEASE, PRESS};
  endfunction

  task automatic wave_clear();
    wave_len = 0;
  endtask

  task automatic wave_add(input bit v, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      if (wave_len < MAXN) begin
        lvl[wave_len] = v;
        wave_len++;
      end
    end
  endtask

  // Reference model. Edge e is the e-th rising clock edge after reset release;
  // lvl[k] is the switch level presented before edge k+1. The synced view
  // shows lvl three edges later. Gestures are resolved from press/release times:
  //   LONG   at P+LONGC   if the button is still down at that edge,
  //   DOUBLE at P2        if the next press edge P2 <= R+DBLC,
  //   SHORT  at R+DBLC    otherwise.
  function automatic void build_model();
    bit d [MAXN+1];
    int pr[$];
    int rl[$];
    int i;
    int p1;
    int r1;
    d[0] = 1'b0;
    for (int e = 1; e <= wave_len; e++) begin
      d[e] = (e >= LAT) ? lvl[e-LAT] : 1'b0;
      expv[e] = {d[e], 3'b000, ~d[e] & d[e-1], d[e] & ~d[e-1]};
      if (d[e] && !d[e-1]) pr.push_back(e);
      if (!d[e] && d[e-1]) rl.push_back(e);
    end
    i = 0;
    while (i < pr.size()) begin
      p1 = pr[i];
      r1 = (i < rl.size()) ? rl[i] : BIG;
      if (r1 > p1 + LONGC) begin
        if (p1 + LONGC <= wave_len) expv[p1+LONGC][3] = 1'b1;
        i += 1;
      end else if (i + 1 < pr.size() && pr[i+1] <= r1 + DBLC) begin
        expv[pr[i+1]][4] = 1'b1;
        i += 2;
      end else begin
        if (r1 + DBLC <= wave_len) expv[r1+DBLC][2] = 1'b1;
        i += 1;
      end
    end
  endfunction

  task automatic apply_reset();
    @(negedge CLOCK);
    NRESET  = 1'b0;
    SWITCHI = lvl[0];
    repeat (3) @(negedge CLOCK);
    NRESET = 1'b1;
  endtask

  // Reset, then play lvl[] and record outputs #1 after each edge.
  task automatic run_wave();
    apply_reset();
    for (int e = 1; e <= wave_len; e++) begin
      @(posedge CLOCK);
      #1;
      obs[e]  = pack_out();
      SWITCHI = (e < wave_len) ? lvl[e] : 1'b0;
    end
    build_model();
  endtask

  task automatic test_reset();
    NRESET = 1'b0;
    for (int k = 0; k < 6; k++) begin
      SWITCHI = k[0];
      @(posedge CLOCK);
      #1;
      n_assert++;
      if (pack_out() !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got %b required 000000", k, pack_out());
      end
    end
    wave_clear();
    wave_add(1'b1, 8);
    wave_add(1'b0, 25);
    run_wave();
    n_assert++;
    if (obs[3] !== 6'b100001) begin
      n_fail++;
      $display("FAIL reset_held_press edge3: got %b required 100001", obs[3]);
    end
    for (int e = 1; e <= wave_len; e++) begin
      n_assert++;
      if (obs[e] !== expv[e]) begin
        n_fail++;
        $display("FAIL reset_held edge %0d: got %b required %b", e, obs[e], expv[e]);
      end
    end
  endtask

  task automatic test_short_click();
    wave_clear();
    wave_add(1'b1, 5);
    wave_add(1'b0, 25);
    run_wave();
    n_assert++;
    if ({obs[3][0], obs[8][1], obs[18][2]} !== 3'b111) begin
      n_fail++;
      $display("FAIL short_timing: press@3 rel@8 short@18 got %b%b%b required 111",
               obs[3][0], obs[8][1], obs[18][2]);
    end
    for (int e = 1; e <= wave_len; e++) begin
      n_assert++;
      if (obs[e] !== expv[e]) begin
        n_fail++;
        $display("FAIL short_click edge %0d: got %b required %b", e, obs[e], expv[e]);
      end
    end
  endtask

  task automatic test_long_press();
    wave_clear();
    wave_add(1'b1, 30);
    wave_add(1'b0, 20);
    run_wave();
    n_assert++;
    if ({obs[23][3], obs[33][1]} !== 2'b11) begin
      n_fail++;
      $display("FAIL long_timing: long@23 rel@33 got %b%b required 11", obs[23][3], obs[33][1]);
    end
    for (int e = 1; e <= wave_len; e++) begin
      n_assert++;
      if (obs[e] !== expv[e]) begin
        n_fail++;
        $display("FAIL long_press edge %0d: got %b required %b", e, obs[e], expv[e]);
      end
    end
  endtask

  task automatic test_double_click();
    wave_clear();
    wave_add(1'b1, 5);
    wave_add(1'b0, 4);
    wave_add(1'b1, 5);
    wave_add(1'b0, 4);
    wave_add(1'b1, 5);
    wave_add(1'b0, 20);
    run_wave();
    n_assert++;
    if ({obs[12][4], obs[12][0], obs[21][4], obs[36][2]} !== 4'b1101) begin
      n_fail++;
      $display("FAIL double_timing: dbl@12 press@12 nodbl@21 short@36 got %b%b%b%b required 1101",
               obs[12][4], obs[12][0], obs[21][4], obs[36][2]);
    end
    for (int e = 1; e <= wave_len; e++) begin
      n_assert++;
      if (obs[e] !== expv[e]) begin
        n_fail++;
        $display("FAIL double_click edge %0d: got %b required %b", e, obs[e], expv[e]);
      end
    end
  endtask

  task automatic test_window_boundary();
    // Second press detected on the last window count: double click.
    wave_clear();
    wave_add(1'b1, 5);
    wave_add(1'b0, 10);
    wave_add(1'b1, 5);
    wave_add(1'b0, 20);
    run_wave();
    n_assert++;
    if ({obs[18][4], obs[18][2]} !== 2'b10) begin
      n_fail++;
      $display("FAIL window_inside: dbl,short@18 got %b%b required 10", obs[18][4], obs[18][2]);
    end
    for (int e = 1; e <= wave_len; e++) begin
      n_assert++;
      if (obs[e] !== expv[e]) begin
        n_fail++;
        $display("FAIL window_inside edge %0d: got %b required %b", e, obs[e], expv[e]);
      end
    end
    // One cycle later: short click, then a fresh single click.
    wave_clear();
    wave_add(1'b1, 5);
    wave_add(1'b0, 11);
    wave_add(1'b1, 5);
    wave_add(1'b0, 20);
    run_wave();
    n_assert++;
    if ({obs[18][2], obs[19][4], obs[19][0], obs[34][2]} !== 4'b1011) begin
      n_fail++;
      $display("FAIL window_outside: short@18 dbl@19 press@19 short@34 got %b%b%b%b required 1011",
               obs[18][2], obs[19][4], obs[19][0], obs[34][2]);
    end
    for (int e = 1; e <= wave_len; e++) begin
      n_assert++;
      if (obs[e] !== expv[e]) begin
        n_fail++;
        $display("FAIL window_outside edge %0d: got %b required %b", e, obs[e], expv[e]);
      end
    end
  endtask

  task automatic test_reset_mid_gesture();
    wave_clear();
    wave_add(1'b1, 18);
    apply_reset();
    // Press reaches P1 at edge 3; the count is 15 after edge 18.
    for (int e = 1; e <= 18; e++) begin
      @(posedge CLOCK);
      #1;
      obs[e]  = pack_out();
      SWITCHI = 1'b1;
    end
    build_model();
    for (int e = 1; e <= 18; e++) begin
      n_assert++;
      if (obs[e] !== expv[e]) begin
        n_fail++;
        $display("FAIL midreset_pre edge %0d: got %b required %b", e, obs[e], expv[e]);
      end
    end
    #2;
    NRESET  = 1'b0;
    SWITCHI = 1'b0;
    #1;
    n_assert++;
    if (pack_out() !== 6'b0) begin
      n_fail++;
      $display("FAIL midreset_immediate: got %b required 000000", pack_out());
    end
    repeat (3) @(negedge CLOCK);
    NRESET = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge CLOCK);
      #1;
      n_assert++;
      if (pack_out() !== 6'b0) begin
        n_fail++;
        $display("FAIL midreset_after edge %0d: got %b required 000000", e, pack_out());
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      wave_clear();
      if ($urandom_range(0, 1) == 0) wave_add(1'b0, int'($urandom_range(1, 6)));
      while (wave_len < 250) begin
        wave_add(1'b1, int'($urandom_range(1, 30)));
        wave_add(1'b0, int'($urandom_range(1, 14)));
      end
      wave_add(1'b0, 30);
      run_wave();
      for (int e = 1; e <= wave_len; e++) begin
        n_assert++;
        if (obs[e] !== expv[e]) begin
          n_fail++;
          $display("FAIL random%0d edge %0d: got %b required %b", it, e, obs[e], expv[e]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_short_click();
    test_long_press();
    test_double_click();
    test_window_boundary();
    test_reset_mid_gesture();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
